// File: rtl/dff_response_checker_pkg.sv
// Shared types for the flip-flop response checker.
// State encodings and default counter widths.
package dff_response_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FAIL   = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 8;
  localparam int CYC_W_DEF = 16;

endpackage

// File: rtl/dff_response_checker_delay_line.sv
// Golden delay line: LATENCY-deep {valid,d} shift register.
// flush clears every valid bit so re-entry never compares stale data.
module dff_response_checker_delay_line #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic flush,
  input  logic d,
  output logic tail_vld,
  output logic tail_d,
  output logic near_vld
);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (push) begin
      vld_d[0] = 1'b1;
      dat_d[0] = d;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign tail_vld = vld_q[LATENCY-1];
  assign tail_d   = dat_q[LATENCY-1];

  // high when this push makes the tail valid on the next cycle
  generate
    if (LATENCY == 1) begin : g_l1
      assign near_vld = push;
    end else begin : g_ln
      assign near_vld = push && vld_q[LATENCY-2];
    end
  endgenerate

endmodule

// File: rtl/dff_response_checker.sv
// Response checker for a flip-flop under test: golden q prediction,
// q/qbar compare, saturating statistics. Define DFF_CHK_MASK_EN for mask.
module dff_response_checker
  import dff_response_checker_pkg::*;
#(
  parameter int LATENCY   = 1,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int CYC_W     = CYC_W_DEF,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             d,
  input  logic             q,
  input  logic             qbar,
`ifdef DFF_CHK_MASK_EN
  input  logic             mask,
`endif
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CYC_W-1:0] first_err_cycle,
  output logic             fail,
  output logic [1:0]       state
);

  state_e           state_q;
  logic             mis_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] first_q;

  logic active, push, flush, msk;
  logic cmp, bad, err, lim_hit;
  logic tail_vld, tail_d, near_vld;

  assign active = (state_q == ST_WARMUP) || (state_q == ST_CHECK);
  assign push   = active && enable;
  assign flush  = active && !enable;

`ifdef DFF_CHK_MASK_EN
  assign msk = mask;
`else
  assign msk = 1'b0;
`endif

  dff_response_checker_delay_line #(
    .LATENCY (LATENCY)
  ) u_dl (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .flush    (flush),
    .d        (d),
    .tail_vld (tail_vld),
    .tail_d   (tail_d),
    .near_vld (near_vld)
  );

  // case-equality so X/Z on q or qbar is a failure
  assign cmp = (state_q == ST_CHECK) && enable
            && tail_vld && !msk;
  assign bad = (q !== tail_d) || (qbar !== ~q);
  assign err = cmp && bad;

  assign cnt_d = (err && cnt_q != '1)
               ? cnt_q + 1'b1 : cnt_q;
  assign cyc_d = ((state_q == ST_CHECK) && enable
               && cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;

  assign lim_hit = err && (ERR_LIMIT != 0)
                && (32'(cnt_d) >= ERR_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      first_q <= '0;
    end else begin
      mis_q <= err;
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
      if (err && cnt_q == '0) first_q <= cyc_q;
      unique case (state_q)
        ST_IDLE:
          if (enable) state_q <= ST_WARMUP;
        ST_WARMUP:
          if (!enable) state_q <= ST_IDLE;
          else if (near_vld) state_q <= ST_CHECK;
        ST_CHECK:
          if (!enable) state_q <= ST_IDLE;
          else if (lim_hit) state_q <= ST_FAIL;
        ST_FAIL:
          state_q <= ST_FAIL;
        default:
          state_q <= ST_IDLE;
      endcase
    end
  end

  assign mismatch        = mis_q;
  assign err_count       = cnt_q;
  assign first_err_cycle = first_q;
  assign fail            = (state_q == ST_FAIL);
  assign state           = state_q;

endmodule
